mic1_sequencer: RTL and testbench

Parametrised microprogram sequencer for the MIC-1 datapath: computes and registers the next microprogram counter (MPC) from the microinstruction's next-address field, JAM bits, ALU flags and MBR. It extends the basic next-address logic with configurable widths, a selectable flag-timing mode, a memory-wait stall, and a bounded micro-subroutine call/return stack with sticky error flags. It sits between the control store (MIR) and the datapath and drives the control-store address.

---
 rtl/mic1_sequencer.sv | 128 ++++++++++++
 tb/tb_mic1_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mic1_sequencer.sv
// MIC-1 microprogram sequencer: forms the next MPC from the MIR next-address field,
// JAM/JMPC modifiers and a bounded call/return stack, with a memory-wait stall.
module mic1_sequencer #(
    parameter int                ADDR_W      = 9,
    parameter int                MBR_W       = 8,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
    parameter bit                FLAG_BYPASS = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             n,
    input  logic                             z,
    input  logic [MBR_W-1:0]                 mbr,
    input  logic [ADDR_W-1:0]                next_addr,
    input  logic                             jmpc,
    input  logic                             jamn,
    input  logic                             jamz,
    input  logic [1:0]                       seq_op,
    input  logic                             stall,
    output logic [ADDR_W-1:0]                mpc,
    output logic [$clog2(STACK_DEPTH+1)-1:0] sp,
    output logic                             ovf,
    output logic                             udf
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [1:0] {
        OP_BRANCH = 2'b00,
        OP_CALL   = 2'b01,
        OP_RETURN = 2'b10,
        OP_RSVD   = 2'b11
    } seq_op_t;

    logic [ADDR_W-1:0] stack [STACK_DEPTH];
    logic              n_q, z_q;
    logic              n_eff, z_eff;
    logic [ADDR_W-1:0] target;
    logic              full, empty;
    logic [IDX_W-1:0]  push_idx, pop_idx;
    logic [SP_W-1:0]   sp_minus_one;
    logic [ADDR_W-1:0] mpc_next;
    logic [SP_W-1:0]   sp_next;
    logic              ovf_next, udf_next;
    logic              push_en;
    seq_op_t           op;

    assign op    = seq_op_t'(seq_op);
    assign n_eff = FLAG_BYPASS ? n : n_q;
    assign z_eff = FLAG_BYPASS ? z : z_q;
    assign full  = (sp == SP_W'(STACK_DEPTH));
    assign empty = (sp == '0);

    // Push slot is only used when not full and pop slot only when not empty,
    // so truncating the occupancy to an array index is always in range.
    assign sp_minus_one = sp - SP_W'(1);
    assign push_idx     = IDX_W'(sp);
    assign pop_idx      = IDX_W'(sp_minus_one);

    always_comb begin
        target = next_addr;
        if (jmpc) begin
            target[MBR_W-1:0] = next_addr[MBR_W-1:0] | mbr;
        end
        target[ADDR_W-1] = next_addr[ADDR_W-1] | (jamz & z_eff) | (jamn & n_eff);
    end

    always_comb begin
        mpc_next = mpc;
        sp_next  = sp;
        ovf_next = ovf;
        udf_next = udf;
        push_en  = 1'b0;
        if (!stall) begin
            case (op)
                OP_CALL: begin
                    mpc_next = target;
                    if (full) begin
                        ovf_next = 1'b1;
                    end else begin
                        push_en = 1'b1;
                        sp_next = sp + SP_W'(1);
                    end
                end
                OP_RETURN: begin
                    if (empty) begin
                        mpc_next = RESET_ADDR;
                        udf_next = 1'b1;
                    end else begin
                        mpc_next = stack[pop_idx];
                        sp_next  = sp_minus_one;
                    end
                end
                default: mpc_next = target;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mpc <= RESET_ADDR;
            sp  <= '0;
            ovf <= 1'b0;
            udf <= 1'b0;
            n_q <= 1'b0;
            z_q <= 1'b0;
        end else begin
            mpc <= mpc_next;
            sp  <= sp_next;
            ovf <= ovf_next;
            udf <= udf_next;
            if (!stall) begin
                n_q <= n;
                z_q <= z;
            end
        end
    end

    // Stack storage needs no reset: entries at or above sp are never read.
    always_ff @(posedge clk) begin
        if (!rst && push_en) begin
            stack[push_idx] <= mpc + ADDR_W'(1);
        end
    end

endmodule

// File: tb/tb_mic1_sequencer.sv
// Scoreboard bench for mic1_sequencer: a behavioural model predicts each cycle's
// registered outputs, which are queued at drive time and compared after the edge.
module tb_mic1_sequencer;

    localparam int         ADDR_W = 9;
    localparam int         MBR_W  = 8;
    localparam int         DEPTH  = 4;
    localparam logic [8:0] RADDR  = 9'h000;
    localparam bit         FB     = 1'b0;

    typedef struct packed {
        logic [8:0] mpc;
        logic [2:0] sp;
        logic       ovf;
        logic       udf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       n = 1'b0, z = 1'b0;
    logic [7:0] mbr = '0;
    logic [8:0] next_addr = '0;
    logic       jmpc = 1'b0, jamn = 1'b0, jamz = 1'b0;
    logic [1:0] seq_op = 2'b00;
    logic       stall = 1'b0;
    logic [8:0] mpc;
    logic [2:0] sp;
    logic       ovf, udf;

    int total = 0;
    int bad   = 0;

    exp_t       sb[$];
    logic [8:0] m_stack[$];
    logic [8:0] m_mpc;
    logic       m_ovf, m_udf, m_nq, m_zq;

    mic1_sequencer #(
        .ADDR_W(ADDR_W), .MBR_W(MBR_W), .STACK_DEPTH(DEPTH),
        .RESET_ADDR(RADDR), .FLAG_BYPASS(FB)
    ) dut (
        .clk(clk), .rst(rst), .n(n), .z(z), .mbr(mbr), .next_addr(next_addr),
        .jmpc(jmpc), .jamn(jamn), .jamz(jamz), .seq_op(seq_op), .stall(stall),
        .mpc(mpc), .sp(sp), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic popAndCheck();
        exp_t e;
        if (sb.size() == 0) begin
            checkOutput("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            checkOutput("sb_mpc", 32'(mpc), 32'(e.mpc));
            checkOutput("sb_sp",  32'(sp),  32'(e.sp));
            checkOutput("sb_ovf", 32'(ovf), 32'(e.ovf));
            checkOutput("sb_udf", 32'(udf), 32'(e.udf));
        end
    endtask

    // Reset for two edges (optionally with stall held high), then check reset state.
    task automatic applyReset(input logic st);
        @(negedge clk);
        rst   = 1'b1;
        stall = st;
        seq_op = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        m_stack.delete();
        sb.delete();
        m_mpc = RADDR;
        m_ovf = 1'b0; m_udf = 1'b0; m_nq = 1'b0; m_zq = 1'b0;
        checkOutput("rst_mpc", 32'(mpc), 32'(RADDR));
        checkOutput("rst_sp",  32'(sp),  32'd0);
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
        checkOutput("rst_udf", 32'(udf), 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        stall  = 1'b0;
        seq_op = 2'b00;
    endtask

    task automatic applyStimulus(input logic [8:0] na, input logic jm, input logic [7:0] mb,
                                 input logic jn, input logic jz, input logic [1:0] op,
                                 input logic st, input logic nn, input logic zz);
        logic [8:0] t;
        logic       ne, ze;
        exp_t       e;
        @(negedge clk);
        next_addr = na; jmpc = jm; mbr = mb; jamn = jn; jamz = jz;
        seq_op = op; stall = st; n = nn; z = zz;
        if (!st) begin
            ne = FB ? nn : m_nq;
            ze = FB ? zz : m_zq;
            t = na;
            if (jm) t[7:0] = na[7:0] | mb;
            t[8] = na[8] | (jz & ze) | (jn & ne);
            case (op)
                2'b01: begin
                    if (m_stack.size() == DEPTH) m_ovf = 1'b1;
                    else m_stack.push_back(m_mpc + 9'd1);
                    m_mpc = t;
                end
                2'b10: begin
                    if (m_stack.size() == 0) begin
                        m_mpc = RADDR;
                        m_udf = 1'b1;
                    end else begin
                        m_mpc = m_stack.pop_back();
                    end
                end
                default: m_mpc = t;
            endcase
            m_nq = nn;
            m_zq = zz;
        end
        e.mpc = m_mpc;
        e.sp  = 3'(m_stack.size());
        e.ovf = m_ovf;
        e.udf = m_udf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        popAndCheck();
    endtask

    task automatic branchTo(input logic [8:0] na);
        applyStimulus(na, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic callTo(input logic [8:0] na);
        applyStimulus(na, 1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic doReturn();
        applyStimulus(9'h1AA, 1'b1, 8'hFF, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        applyReset(1'b0);

        branchTo(9'h012);
        checkOutput("branch", 32'(mpc), 32'h012);

        applyStimulus(9'h100, 1'b1, 8'h36, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("jmpc_a", 32'(mpc), 32'h136);
        applyStimulus(9'h005, 1'b1, 8'h0A, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("jmpc_bitwise", 32'(mpc), 32'h00F);
        applyStimulus(9'h0C4, 1'b0, 8'h0A, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
        checkOutput("op11_branch", 32'(mpc), 32'h0C4);

        // JAMZ uses the flag registered on the previous cycle, not the live one.
        applyStimulus(9'h030, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        applyStimulus(9'h020, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("jamz_taken", 32'(mpc), 32'h120);
        applyStimulus(9'h020, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("jamz_not", 32'(mpc), 32'h020);
        applyStimulus(9'h020, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        checkOutput("jamz_live_ignored", 32'(mpc), 32'h020);
        applyStimulus(9'h030, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        applyStimulus(9'h040, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("jamn_taken", 32'(mpc), 32'h140);

        branchTo(9'h010);
        callTo(9'h080);
        checkOutput("call1_mpc", 32'(mpc), 32'h080);
        checkOutput("call1_sp", 32'(sp), 32'd1);
        callTo(9'h0C0);
        checkOutput("call2_sp", 32'(sp), 32'd2);
        doReturn();
        checkOutput("ret1_mpc", 32'(mpc), 32'h081);
        doReturn();
        checkOutput("ret2_mpc", 32'(mpc), 32'h011);
        checkOutput("ret2_sp", 32'(sp), 32'd0);

        // Overflow sequence starting from the top address to exercise the wrap push.
        branchTo(9'h1FF);
        for (int i = 0; i < 5; i++) callTo(9'h0A0 + 9'(i));
        checkOutput("ovf_sp", 32'(sp), 32'd4);
        checkOutput("ovf_flag", 32'(ovf), 32'd1);
        checkOutput("ovf_mpc", 32'(mpc), 32'h0A4);
        doReturn();
        checkOutput("pop_a3", 32'(mpc), 32'h0A3);
        doReturn();
        doReturn();
        doReturn();
        checkOutput("pop_wrap", 32'(mpc), 32'h000);
        doReturn();
        checkOutput("udf_flag", 32'(udf), 32'd1);
        checkOutput("udf_mpc", 32'(mpc), 32'(RADDR));
        branchTo(9'h033);
        checkOutput("ovf_sticky", 32'(ovf), 32'd1);
        checkOutput("udf_sticky", 32'(udf), 32'd1);

        // Stall with a pending call and toggling flags; the release call must
        // see the pre-stall z (0) and push exactly once.
        applyReset(1'b0);
        branchTo(9'h050);
        for (int i = 0; i < 3; i++)
            applyStimulus(9'h070, 1'b0, 8'h00, 1'b1, 1'b1, 2'b01, 1'b1, 1'(i), 1'b1);
        checkOutput("stall_mpc", 32'(mpc), 32'h050);
        checkOutput("stall_sp", 32'(sp), 32'd0);
        applyStimulus(9'h070, 1'b0, 8'h00, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        checkOutput("release_mpc", 32'(mpc), 32'h070);
        checkOutput("release_sp", 32'(sp), 32'd1);

        // Reset mid-subroutine, asserted together with stall, empties the stack.
        applyReset(1'b1);
        doReturn();
        checkOutput("post_rst_udf", 32'(udf), 32'd1);
        checkOutput("post_rst_mpc", 32'(mpc), 32'(RADDR));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
